// File: rtl/flash_sched_pkg.sv
// Shared types and constants for the flash read scheduler.
package flash_sched_pkg;

  localparam int FLASH_ADDR_W = 24;
  localparam int FLASH_DATA_W = 32;
  localparam int WORD_BYTES   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CPU_RD,
    CPU_GAP,
    DMA_RD,
    DMA_FIN
  } sched_state_e;

endpackage

// File: rtl/flash_read_scheduler.sv
// Arbitrates the single SPI flash read engine between CPU single-word fetches
// and chunked DMA bursts, so a pending CPU fetch slots in between DMA chunks.
module flash_read_scheduler
  import flash_sched_pkg::*;
#(
  parameter int CHUNK_WORDS = 16,
  parameter int ADDR_WIDTH  = FLASH_ADDR_W
) (
  input  logic                    clk_cpu,
  input  logic                    reset,
  input  logic                    cpu_valid,
  input  logic [ADDR_WIDTH-1:0]   cpu_address,
  output logic                    cpu_strobe,
  output logic [FLASH_DATA_W-1:0] cpu_data,
  input  logic                    dma_valid,
  input  logic [ADDR_WIDTH-1:0]   dma_address,
  input  logic [ADDR_WIDTH-1:0]   dma_word_count,
  output logic                    dma_ack,
  output logic                    dma_busy,
  output logic                    dma_strobe,
  output logic [FLASH_DATA_W-1:0] dma_data,
  output logic                    dma_done,
  output logic                    rd_start,
  output logic [ADDR_WIDTH-1:0]   rd_address,
  output logic [ADDR_WIDTH-1:0]   rd_word_count,
  input  logic                    rd_strobe,
  input  logic                    rd_done,
  input  logic [FLASH_DATA_W-1:0] rd_data
);

  localparam logic [ADDR_WIDTH-1:0] CHUNK_LEN = ADDR_WIDTH'(CHUNK_WORDS);

  function automatic logic [ADDR_WIDTH-1:0] chunk_len(input logic [ADDR_WIDTH-1:0] rem);
    return (rem < CHUNK_LEN) ? rem : CHUNK_LEN;
  endfunction

  sched_state_e          state, state_n;
  logic                  rd_start_n, dma_ack_n, dma_done_n, dma_busy_n;
  logic [ADDR_WIDTH-1:0] rd_address_n, rd_word_count_n;
  logic [ADDR_WIDTH-1:0] dma_addr, dma_addr_n, dma_rem, dma_rem_n;

  // Reader data is forwarded unregistered; the strobe is steered by owner.
  assign cpu_strobe = rd_strobe & (state == CPU_RD);
  assign dma_strobe = rd_strobe & (state == DMA_RD);
  assign cpu_data   = rd_data;
  assign dma_data   = rd_data;

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rd_start      <= 1'b0;
      rd_address    <= '0;
      rd_word_count <= '0;
      dma_ack       <= 1'b0;
      dma_busy      <= 1'b0;
      dma_done      <= 1'b0;
      dma_addr      <= '0;
      dma_rem       <= '0;
    end else begin
      state         <= state_n;
      rd_start      <= rd_start_n;
      rd_address    <= rd_address_n;
      rd_word_count <= rd_word_count_n;
      dma_ack       <= dma_ack_n;
      dma_busy      <= dma_busy_n;
      dma_done      <= dma_done_n;
      dma_addr      <= dma_addr_n;
      dma_rem       <= dma_rem_n;
    end
  end

  always_comb begin
    state_n         = state;
    rd_start_n      = 1'b0;
    dma_ack_n       = 1'b0;
    dma_done_n      = 1'b0;
    dma_busy_n      = dma_busy;
    rd_address_n    = rd_address;
    rd_word_count_n = rd_word_count;
    dma_addr_n      = dma_addr;
    dma_rem_n       = dma_rem;
    unique case (state)
      IDLE: begin
        if (cpu_valid) begin
          state_n         = CPU_RD;
          rd_address_n    = cpu_address;
          rd_word_count_n = ADDR_WIDTH'(1);
          rd_start_n      = 1'b1;
        end else if (dma_busy && dma_rem != '0) begin
          state_n         = DMA_RD;
          rd_address_n    = dma_addr;
          rd_word_count_n = chunk_len(dma_rem);
          rd_start_n      = 1'b1;
        end else if (dma_valid && !dma_busy) begin
          // Accept only; the first chunk is issued from IDLE next cycle so
          // a CPU request arriving meanwhile still wins.
          dma_ack_n  = 1'b1;
          dma_busy_n = 1'b1;
          dma_addr_n = dma_address;
          dma_rem_n  = dma_word_count;
          if (dma_word_count == '0) state_n = DMA_FIN;
        end
      end
      CPU_RD: begin
        if (rd_done) state_n = CPU_GAP;
      end
      CPU_GAP: state_n = IDLE;
      DMA_RD: begin
        if (rd_done) begin
          dma_rem_n  = dma_rem - rd_word_count;
          dma_addr_n = dma_addr + ADDR_WIDTH'(rd_word_count * WORD_BYTES);
          state_n    = (dma_rem_n == '0) ? DMA_FIN : IDLE;
        end
      end
      DMA_FIN: begin
        dma_done_n = 1'b1;
        dma_busy_n = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flash_read_scheduler.sv
// Scoreboard bench: drivers push expected CPU words, DMA words and DMA chunks;
// a negedge monitor pops and compares; a behavioural flash reader responds.
module tb_flash_read_scheduler;

  localparam int CHUNK = 16;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic [23:0] cpu_address;
  logic        cpu_strobe;
  logic [31:0] cpu_data;
  logic        dma_valid;
  logic [23:0] dma_address;
  logic [23:0] dma_word_count;
  logic        dma_ack, dma_busy, dma_strobe, dma_done;
  logic [31:0] dma_data;
  logic        rd_start;
  logic [23:0] rd_address, rd_word_count;
  logic        rd_strobe, rd_done;
  logic [31:0] rd_data;

  flash_read_scheduler #(.CHUNK_WORDS(CHUNK), .ADDR_WIDTH(24)) dut (
    .clk_cpu(clk_cpu), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_address(cpu_address),
    .cpu_strobe(cpu_strobe), .cpu_data(cpu_data),
    .dma_valid(dma_valid), .dma_address(dma_address), .dma_word_count(dma_word_count),
    .dma_ack(dma_ack), .dma_busy(dma_busy), .dma_strobe(dma_strobe),
    .dma_data(dma_data), .dma_done(dma_done),
    .rd_start(rd_start), .rd_address(rd_address), .rd_word_count(rd_word_count),
    .rd_strobe(rd_strobe), .rd_done(rd_done), .rd_data(rd_data)
  );

  always #5 clk_cpu = ~clk_cpu;

  int errors = 0;
  int checks = 0;

  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  logic [23:0] ch_addr_q[$];
  logic [23:0] ch_cnt_q[$];
  int          done_pend = 0;
  int          dma_starts = 0;
  int          rst_epoch = 0;
  bit          resp_busy = 0;

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    return {8'hA5, a} ^ (32'(a) * 32'h9E37_79B1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard.
  bit          prev_cv = 0;
  logic [23:0] prev_ca = '0;
  int          cur_kind = 0;  // 0 none, 1 cpu read, 2 dma chunk
  int          gap = 0;

  always @(negedge clk_cpu) begin
    if (reset) begin
      cur_kind = 0;
      gap = 0;
    end else begin
      if (gap > 0) begin
        chk("cpu_gap_no_start", rd_start, 0);
        gap--;
      end
      if (cpu_strobe) begin
        chk("cpu_strobe_expected", cpu_q.size() > 0, 1);
        if (cpu_q.size() > 0) chk("cpu_data", cpu_data, cpu_q.pop_front());
      end
      if (dma_strobe) begin
        chk("dma_strobe_expected", dma_q.size() > 0, 1);
        if (dma_q.size() > 0) chk("dma_data", dma_data, dma_q.pop_front());
      end
      if (dma_done) begin
        chk("dma_done_expected", done_pend > 0, 1);
        if (done_pend > 0) done_pend--;
      end
      if (rd_done && cur_kind != 0) begin
        if (cur_kind == 1) gap = 2;
        cur_kind = 0;
      end
      if (rd_start) begin
        // A CPU request present at the deciding edge always wins.
        if (prev_cv) begin
          chk("cpu_rd_address", rd_address, prev_ca);
          chk("cpu_rd_count", rd_word_count, 1);
          cur_kind = 1;
        end else begin
          chk("dma_chunk_expected", ch_addr_q.size() > 0, 1);
          if (ch_addr_q.size() > 0) begin
            chk("dma_chunk_address", rd_address, ch_addr_q.pop_front());
            chk("dma_chunk_count", rd_word_count, ch_cnt_q.pop_front());
          end
          cur_kind = 2;
          dma_starts++;
        end
      end
    end
    prev_cv = cpu_valid;
    prev_ca = cpu_address;
  end

  // Behavioural flash reader.
  initial begin
    logic [23:0] a, n;
    int ep;
    bit both;
    rd_strobe = 0; rd_done = 0; rd_data = '0;
    forever begin
      @(negedge clk_cpu);
      if (rd_start && !reset) begin
        a = rd_address; n = rd_word_count; ep = rst_epoch; resp_busy = 1;
        repeat ($urandom_range(0, 2)) @(posedge clk_cpu);
        both = 0;
        for (int i = 0; i < int'(n); i++) begin
          @(posedge clk_cpu); #1;
          rd_strobe = 1;
          rd_data = flash_word(a + 24'(i * 4));
          if (i == int'(n) - 1 && $urandom_range(0, 1) == 1) begin
            both = 1;
            rd_done = 1;
          end
          @(posedge clk_cpu); #1;
          rd_strobe = 0; rd_done = 0;
          repeat ($urandom_range(0, 1)) @(posedge clk_cpu);
        end
        if (!both) begin
          @(posedge clk_cpu); #1 rd_done = 1;
          if (ep == rst_epoch) begin
            chk("rd_address_stable", rd_address, a);
            chk("rd_count_stable", rd_word_count, n);
          end
          @(posedge clk_cpu); #1 rd_done = 0;
        end
        resp_busy = 0;
      end
    end
  end

  task automatic cpu_read(input logic [23:0] a, input bit chk_lat);
    int t;
    @(posedge clk_cpu); #1;
    cpu_valid = 1; cpu_address = a;
    cpu_q.push_back(flash_word(a));
    if (chk_lat) begin
      @(negedge clk_cpu);
      chk("cpu_latency_pre", rd_start, 0);
      @(negedge clk_cpu);
      chk("cpu_latency_start", rd_start, 1);
    end
    t = 0;
    while (t < 500) begin
      @(negedge clk_cpu);
      if (cpu_strobe) break;
      t++;
    end
    chk("cpu_strobe_seen", cpu_strobe, 1);
    @(posedge clk_cpu); #1 cpu_valid = 0;
  endtask

  task automatic dma_burst(input logic [23:0] a, input logic [23:0] n, input bit wait_done);
    logic [23:0] rem, ca, c;
    int t;
    @(posedge clk_cpu); #1;
    dma_valid = 1; dma_address = a; dma_word_count = n;
    for (int i = 0; i < int'(n); i++) dma_q.push_back(flash_word(a + 24'(i * 4)));
    rem = n; ca = a;
    while (rem != 0) begin
      c = (int'(rem) < CHUNK) ? rem : 24'(CHUNK);
      ch_addr_q.push_back(ca);
      ch_cnt_q.push_back(c);
      ca = ca + 24'(int'(c) * 4);
      rem = rem - c;
    end
    done_pend++;
    t = 0;
    while (t < 2000) begin
      @(negedge clk_cpu);
      if (dma_ack) break;
      t++;
    end
    chk("dma_ack_seen", dma_ack, 1);
    dma_valid = 0;
    if (wait_done) begin
      t = 0;
      while (t < 5000) begin
        @(negedge clk_cpu);
        if (dma_done) break;
        t++;
      end
      chk("dma_done_seen", dma_done, 1);
    end
  endtask

  task automatic wait_dma_idle();
    int t = 0;
    while ((done_pend > 0 || resp_busy) && t < 5000) begin
      @(negedge clk_cpu);
      t++;
    end
    chk("dma_idle_reached", done_pend == 0, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_start", rd_start, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_dma_busy", dma_busy, 0);
    chk("rst_dma_done", dma_done, 0);
    chk("rst_cpu_strobe", cpu_strobe, 0);
    chk("rst_dma_strobe", dma_strobe, 0);
    chk("rst_rd_address", rd_address, 0);
    chk("rst_rd_count", rd_word_count, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1; cpu_valid = 0; cpu_address = '0;
    dma_valid = 0; dma_address = '0; dma_word_count = '0;
    repeat (3) @(posedge clk_cpu);
    @(negedge clk_cpu);
    check_reset_outputs();
    @(posedge clk_cpu); #1 reset = 0;
    repeat (3) @(posedge clk_cpu);

    // CPU only, with start latency and post-done gap
    cpu_read(24'h000100, 1);
    repeat (6) @(posedge clk_cpu);

    // DMA split 16/16/8
    dma_burst(24'h010000, 24'd40, 1);
    chk("split_words_drained", dma_q.size(), 0);
    repeat (4) @(posedge clk_cpu);

    // Contention: CPU raised during first chunk is served before the second
    dma_starts = 0;
    dma_burst(24'h010000, 24'd40, 0);
    t = 0;
    while (dma_starts < 1 && t < 200) begin @(negedge clk_cpu); t++; end
    chk("contention_first_chunk", dma_starts, 1);
    cpu_read(24'h000200, 0);
    chk("contention_cpu_before_second", dma_starts, 1);
    wait_dma_idle();

    // Zero-length burst
    repeat (4) @(posedge clk_cpu);
    dma_burst(24'h123400, 24'd0, 0);
    chk("zero_busy_at_ack", dma_busy, 1);
    chk("zero_done_not_yet", dma_done, 0);
    @(negedge clk_cpu);
    chk("zero_done", dma_done, 1);
    chk("zero_busy_clear", dma_busy, 0);
    repeat (4) @(posedge clk_cpu);

    // Address wrap across the top of the flash space
    dma_burst(24'hFFFFC0, 24'd32, 1);
    repeat (4) @(posedge clk_cpu);

    // Reset during the second chunk
    dma_starts = 0;
    dma_burst(24'h010000, 24'd40, 0);
    t = 0;
    while (dma_starts < 2 && t < 500) begin @(negedge clk_cpu); t++; end
    chk("reset_second_chunk_reached", dma_starts, 2);
    repeat (3) @(posedge clk_cpu);
    #1 reset = 1;
    rst_epoch++;
    cpu_q.delete(); dma_q.delete(); ch_addr_q.delete(); ch_cnt_q.delete();
    done_pend = 0;
    @(negedge clk_cpu);
    check_reset_outputs();
    @(posedge clk_cpu); #1 reset = 0;
    t = 0;
    while (resp_busy && t < 500) begin @(negedge clk_cpu); t++; end
    chk("stale_reader_finished", resp_busy, 0);
    repeat (5) @(posedge clk_cpu);
    cpu_read(24'h000ABC, 1);
    repeat (6) @(posedge clk_cpu);

    // Randomized concurrent CPU and DMA traffic
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic [23:0] a;
          a = (k % 3 == 0) ? 24'hFFFF00 : (24'($urandom) & 24'hFFFFFC);
          dma_burst(a, 24'($urandom_range(0, 50)), 1);
          repeat ($urandom_range(0, 6)) @(posedge clk_cpu);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 12)) @(posedge clk_cpu);
          cpu_read(24'($urandom), 0);
        end
      end
    join
    wait_dma_idle();
    repeat (10) @(posedge clk_cpu);

    chk("end_cpu_q_empty", cpu_q.size(), 0);
    chk("end_dma_q_empty", dma_q.size(), 0);
    chk("end_chunks_empty", ch_addr_q.size(), 0);
    chk("end_done_pending", done_pend, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
